// File: rtl/depo_pkg.sv
// Shared definitions for the 64<->32 storage word packers (depo_bosalt / doldur).
// State codes and default widths live here so both ends of the path agree.
package depo_pkg;

  localparam int unsigned VERI_W_VARS  = 32;
  localparam int unsigned SAYAC_W_VARS = 16;

  localparam logic [1:0] BOS   = 2'b00;
  localparam logic [1:0] YARI0 = 2'b01;
  localparam logic [1:0] YARI1 = 2'b10;

endpackage

// File: rtl/depo_bosalt.sv
// Unloads one held 2*VERI_W storage word as two VERI_W half-words over valid/ready,
// refilling in the same edge as the last half leaves so streaming has no bubble.
module depo_bosalt
  import depo_pkg::*;
#(
  parameter int unsigned VERI_W     = VERI_W_VARS,
  parameter bit          DUSUK_ONCE = 1'b1,
  parameter int unsigned SAYAC_W    = SAYAC_W_VARS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                temizle,
  input  logic [2*VERI_W-1:0] depo,
  input  logic                depo_gecerli,
  output logic                depo_hazir,
  output logic [VERI_W-1:0]   veri,
  output logic                veri_gecerli,
  input  logic                veri_hazir,
  output logic [SAYAC_W-1:0]  sayac
);

  logic [1:0]          durum_q, durum_d;
  logic [2*VERI_W-1:0] tut_q, tut_d;
  logic [SAYAC_W-1:0]  sayac_q;
  logic [VERI_W-1:0]   ilk, ikinci;
  logic                acc, xfer;

  assign ilk    = DUSUK_ONCE ? tut_q[VERI_W-1:0] : tut_q[2*VERI_W-1:VERI_W];
  assign ikinci = DUSUK_ONCE ? tut_q[2*VERI_W-1:VERI_W] : tut_q[VERI_W-1:0];

  assign veri_gecerli = (durum_q != BOS);
  // rst_n is folded in so ready drops the instant reset asserts
  assign depo_hazir   = rst_n & ~temizle &
                        ((durum_q == BOS) | ((durum_q == YARI1) & veri_hazir));
  assign acc          = depo_gecerli & depo_hazir;
  assign xfer         = veri_gecerli & veri_hazir;
  assign sayac        = sayac_q;

  always_comb begin
    veri = '0;
    case (durum_q)
      YARI0:   veri = ilk;
      YARI1:   veri = ikinci;
      default: veri = '0;
    endcase
  end

  always_comb begin
    durum_d = durum_q;
    tut_d   = tut_q;
    if (temizle) begin
      durum_d = BOS;
      tut_d   = '0;
    end else begin
      case (durum_q)
        BOS: begin
          if (acc) begin
            durum_d = YARI0;
            tut_d   = depo;
          end
        end
        YARI0: begin
          if (xfer) durum_d = YARI1;
        end
        YARI1: begin
          if (xfer && acc) begin
            durum_d = YARI0;
            tut_d   = depo;
          end else if (xfer) begin
            durum_d = BOS;
          end
        end
        default: durum_d = BOS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q <= BOS;
      tut_q   <= '0;
      sayac_q <= '0;
    end else begin
      durum_q <= durum_d;
      tut_q   <= tut_d;
      // a transfer sampled by the consumer still counts during a flush
      if (xfer) sayac_q <= sayac_q + SAYAC_W'(1);
    end
  end

endmodule

// File: tb/tb_depo_bosalt.sv
// Bench for depo_bosalt: two instances (low-first/16-bit count, high-first/3-bit count)
// driven with identical stimulus and checked against queue-based reference models.
module tb_depo_bosalt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        temizle;
  logic [63:0] depo;
  logic        depo_gecerli;
  logic        veri_hazir;

  logic        depo_hazir_a, veri_gecerli_a;
  logic [31:0] veri_a;
  logic [15:0] sayac_a;
  logic        depo_hazir_b, veri_gecerli_b;
  logic [31:0] veri_b;
  logic [2:0]  sayac_b;

  int tests = 0;
  int fails = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int cnt_a = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  depo_bosalt #(.VERI_W(32), .DUSUK_ONCE(1'b1), .SAYAC_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .temizle(temizle), .depo(depo),
    .depo_gecerli(depo_gecerli), .depo_hazir(depo_hazir_a),
    .veri(veri_a), .veri_gecerli(veri_gecerli_a), .veri_hazir(veri_hazir),
    .sayac(sayac_a)
  );

  depo_bosalt #(.VERI_W(32), .DUSUK_ONCE(1'b0), .SAYAC_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .temizle(temizle), .depo(depo),
    .depo_gecerli(depo_gecerli), .depo_hazir(depo_hazir_b),
    .veri(veri_b), .veri_gecerli(veri_gecerli_b), .veri_hazir(veri_hazir),
    .sayac(sayac_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs just after negedge, check against models, advance models at posedge.
  task automatic step(input logic g, input logic [63:0] d, input logic h, input logic t);
    logic rdy_a, rdy_b, acc_a, acc_b, xa, xb;
    depo_gecerli = g; depo = d; veri_hazir = h; temizle = t;
    #1;
    rdy_a = !t && (qa.size() == 0 || (qa.size() == 1 && h));
    rdy_b = !t && (qb.size() == 0 || (qb.size() == 1 && h));
    chk("A.veri_gecerli", veri_gecerli_a, qa.size() != 0);
    chk("A.veri", veri_a, qa.size() != 0 ? qa[0] : 32'h0);
    chk("A.depo_hazir", depo_hazir_a, rdy_a);
    chk("A.sayac", sayac_a, 64'(cnt_a % 65536));
    chk("B.veri_gecerli", veri_gecerli_b, qb.size() != 0);
    chk("B.veri", veri_b, qb.size() != 0 ? qb[0] : 32'h0);
    chk("B.depo_hazir", depo_hazir_b, rdy_b);
    chk("B.sayac", sayac_b, 64'(cnt_b % 8));
    acc_a = g && rdy_a;
    acc_b = g && rdy_b;
    xa = (qa.size() != 0) && h;
    xb = (qb.size() != 0) && h;
    @(posedge clk);
    if (xa) begin void'(qa.pop_front()); cnt_a++; end
    if (xb) begin void'(qb.pop_front()); cnt_b++; end
    if (t) qa.delete();
    else if (acc_a) begin qa.push_back(d[31:0]); qa.push_back(d[63:32]); end
    if (t) qb.delete();
    else if (acc_b) begin qb.push_back(d[63:32]); qb.push_back(d[31:0]); end
    @(negedge clk);
  endtask

  typedef struct {
    logic        g;
    logic [63:0] d;
    logic        h;
    logic        vg;
    logic [31:0] v;
    logic        rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[14];
  logic [63:0] w;

  initial begin
    rst_n = 1'b0; temizle = 1'b0; depo = '0; depo_gecerli = 1'b0; veri_hazir = 1'b0;
    #1;
    chk("reset.veri_gecerli", veri_gecerli_a, 1'b0);
    chk("reset.depo_hazir", depo_hazir_a, 1'b0);
    chk("reset.veri", veri_a, 32'h0);
    chk("reset.sayac", sayac_a, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single word then four back-to-back words, expected values worked out by hand (instance A)
    tbl[0]  = '{1'b1, 64'h1122334455667788, 1'b1, 1'b0, 32'h0,        1'b1, 16'd0};
    tbl[1]  = '{1'b0, 64'h0,                1'b1, 1'b1, 32'h55667788, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 64'h0,                1'b1, 1'b1, 32'h11223344, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 64'h0,                1'b1, 1'b0, 32'h0,        1'b1, 16'd2};
    tbl[4]  = '{1'b1, 64'hAAAA000055550000, 1'b1, 1'b0, 32'h0,        1'b1, 16'd2};
    tbl[5]  = '{1'b1, 64'hAAAA000155550001, 1'b1, 1'b1, 32'h55550000, 1'b0, 16'd2};
    tbl[6]  = '{1'b1, 64'hAAAA000155550001, 1'b1, 1'b1, 32'hAAAA0000, 1'b1, 16'd3};
    tbl[7]  = '{1'b1, 64'hAAAA000255550002, 1'b1, 1'b1, 32'h55550001, 1'b0, 16'd4};
    tbl[8]  = '{1'b1, 64'hAAAA000255550002, 1'b1, 1'b1, 32'hAAAA0001, 1'b1, 16'd5};
    tbl[9]  = '{1'b1, 64'hAAAA000355550003, 1'b1, 1'b1, 32'h55550002, 1'b0, 16'd6};
    tbl[10] = '{1'b1, 64'hAAAA000355550003, 1'b1, 1'b1, 32'hAAAA0002, 1'b1, 16'd7};
    tbl[11] = '{1'b0, 64'h0,                1'b1, 1'b1, 32'h55550003, 1'b0, 16'd8};
    tbl[12] = '{1'b0, 64'h0,                1'b1, 1'b1, 32'hAAAA0003, 1'b1, 16'd9};
    tbl[13] = '{1'b0, 64'h0,                1'b1, 1'b0, 32'h0,        1'b1, 16'd10};
    for (int i = 0; i < 14; i++) begin
      depo_gecerli = tbl[i].g; depo = tbl[i].d; veri_hazir = tbl[i].h; temizle = 1'b0;
      #1;
      chk($sformatf("tbl%0d.veri_gecerli", i), veri_gecerli_a, tbl[i].vg);
      chk($sformatf("tbl%0d.veri", i), veri_a, tbl[i].v);
      chk($sformatf("tbl%0d.depo_hazir", i), depo_hazir_a, tbl[i].rdy);
      chk($sformatf("tbl%0d.sayac", i), sayac_a, tbl[i].cnt);
      step(tbl[i].g, tbl[i].d, tbl[i].h, 1'b0);
    end

    // backpressure in YARI0 with a competing word offered
    step(1'b1, 64'h1122334455667788, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0);
    chk("stall.veri", veri_a, 32'h55667788);
    chk("stall.sayac", sayac_a, 16'd10);
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b0);

    // flush in YARI1 with a concurrent transfer and offered word
    step(1'b1, 64'h0102030405060708, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 64'h9999999988888888, 1'b1, 1'b1);
    chk("flush.veri_gecerli", veri_gecerli_a, 1'b0);
    chk("flush.sayac", sayac_a, 16'd14);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // asynchronous reset while YARI0 is pending
    step(1'b1, 64'h0F0F0F0FF0F0F0F0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.A.veri_gecerli", veri_gecerli_a, 1'b0);
    chk("rst.A.depo_hazir", depo_hazir_a, 1'b0);
    chk("rst.A.veri", veri_a, 32'h0);
    chk("rst.A.sayac", sayac_a, 16'h0);
    chk("rst.B.veri_gecerli", veri_gecerli_b, 1'b0);
    chk("rst.B.sayac", sayac_b, 3'h0);
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // five words streamed: B emits upper halves first and its 3-bit count wraps to 2
    for (int k = 0; k < 5; k++) begin
      w = {32'hC0DE0000 + 32'(k), 32'h0BAD0000 + 32'(k)};
      step(1'b1, w, 1'b1, 1'b0);
      step(1'b1, w, 1'b1, 1'b0);
    end
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("wrap.B.sayac", sayac_b, 3'd2);
    chk("wrap.A.sayac", sayac_a, 16'd10);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1) == 1, {$urandom, $urandom},
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    repeat (3) step(1'b0, 64'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/depo_bosalt.md
Name: depo_bosalt

Overview:
- Unloads 64-bit storage words into a 32-bit word stream. This is the width-down counterpart of the 32-to-64 `doldur` packer.
- Sits between a 64-bit producer and a 32-bit consumer. Both sides use valid/ready handshakes.
- Holds one 64-bit word and emits its two halves in a configurable order. Sustains one 32-bit transfer per clock under back-to-back traffic.

Parameters:
- VERI_W, 32: output word width. The input width is 2*VERI_W.
- DUSUK_ONCE, 1: 1 emits bits [VERI_W-1:0] first; 0 emits the upper half first.
- SAYAC_W, 16: width of the emitted-word counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- temizle  in  1  synchronous flush; discards any held word
- depo  in  2*VERI_W  64-bit input word
- depo_gecerli  in  1  input valid
- depo_hazir  out  1  input ready
- veri  out  VERI_W  output half-word
- veri_gecerli  out  1  output valid
- veri_hazir  in  1  downstream ready
- sayac  out  SAYAC_W  count of completed output transfers, wraps modulo 2^SAYAC_W

Behaviour:
- Reset (rst_n low, asynchronous): every output is forced to its reset value immediately.
  - State = BOS; holding register = 0; sayac = 0.
  - veri = 0; veri_gecerli = 0; depo_hazir = 0.
- States:
  - BOS: empty.
  - YARI0: first half pending.
  - YARI1: second half pending.
- Output signals:
  - veri_gecerli = (state != BOS).
  - veri = the first half in YARI0, the second half in YARI1, 0 in BOS.
  - Both are decoded from registered state only.
- Ready decode: depo_hazir = rst_n & ~temizle & (state==BOS | (state==YARI1 & veri_hazir)). It is combinational through veri_hazir.
- Event names:
  - Input accept (acc) = depo_gecerli & depo_hazir.
  - Output transfer (xfer) = veri_gecerli & veri_hazir.
- Transitions, when temizle = 0:
  - BOS: acc -> YARI0, word latched. Otherwise stay in BOS.
  - YARI0: xfer -> YARI1. Otherwise hold.
  - YARI1 with xfer and acc -> YARI0, new word latched in the same edge (no bubble).
  - YARI1 with xfer only -> BOS.
  - YARI1 with no xfer -> hold.
- Latency: a word accepted at edge N shows its first half on veri, with veri_gecerli = 1, after edge N.
- Throughput: continuous streaming gives one output transfer per cycle and one input accept every 2 cycles.
- Stall: while veri_gecerli = 1 and veri_hazir = 0, veri and the state hold stable. The held word is never overwritten.
- temizle = 1:
  - Next state is BOS and the holding register is cleared.
  - Any simultaneous acc is suppressed, because depo_hazir = 0.
  - An xfer in the same cycle still counts in sayac, since the consumer sampled it.
  - sayac itself is not cleared by temizle.
- Counter: sayac increments by 1 on every xfer. From 2^SAYAC_W - 1 it wraps to 0.
- Reset asserted mid-word: the pending half is lost. After release the block starts in BOS with no spurious veri_gecerli.
- depo_gecerli with depo_hazir = 0: the block neither samples nor records the input. The producer holds the word until accepted.

Decomposition:
- Shared package `depo_pkg`:
  - State encoding: BOS = 2'b00, YARI0 = 2'b01, YARI1 = 2'b10.
  - Default widths VERI_W = 32 and SAYAC_W = 16. These are shared with `doldur` so both ends agree.
- Single module; no sub-module is warranted. The counter and half-select mux stay inline.

Test Plan:
1. Single word, DUSUK_ONCE=1, veri_hazir=1:
   - Stimulus: depo=64'h1122334455667788, valid for 1 cycle.
   - Required: veri=32'h55667788 then 32'h11223344 on consecutive cycles, then veri_gecerli=0; sayac=2.
2. Back-to-back:
   - Stimulus: 4 words with depo_gecerli held high, veri_hazir=1.
   - Required: 8 consecutive transfers with no bubble; depo_hazir pattern 1,0,1,0...; sayac=8.
3. Backpressure:
   - Stimulus: veri_hazir=0 for 5 cycles in YARI0.
   - Required: veri stays 32'h55667788, depo_hazir=0, sayac unchanged; after release the sequence resumes correctly.
4. Flush:
   - Stimulus: temizle=1 in YARI1 while depo_gecerli=1.
   - Required: next cycle state BOS, veri_gecerli=0, new word not accepted; sayac counts the concurrent xfer if veri_hazir=1.
5. Reset mid-word:
   - Stimulus: drop rst_n between clk edges in YARI0.
   - Required: veri_gecerli, depo_hazir, veri, sayac go to 0 immediately; after release the first output matches a freshly supplied word.
6. Order and wrap:
   - Stimulus: DUSUK_ONCE=0, SAYAC_W=3, 5 words.
   - Required: upper half is emitted first; sayac reads 2 (10 mod 8) at the end.
